// File: rtl/spi_regfile_pkg.sv
// Shared types and sizing helpers for the SPI register-file slave.
package spi_regfile_pkg;

    typedef enum logic [1:0] {
        ST_HDR = 2'd0,
        ST_WR  = 2'd1,
        ST_RD  = 2'd2
    } state_e;

    localparam int DEF_AW   = 7;
    localparam int HDR_BITS = 1 + DEF_AW;

    function automatic int hdr_bits(input int aw);
        return 1 + aw;
    endfunction

    function automatic int cnt_width(input int aw, input int dw);
        int m;
        m = (hdr_bits(aw) > dw) ? hdr_bits(aw) : dw;
        return $clog2(m);
    endfunction

endpackage

// File: rtl/spi_regfile_slave_regbank.sv
// NREG x DW register storage with read-only status mux and out-of-range zero.
module spi_regbank
    import spi_regfile_pkg::*;
#(
    parameter int              DW      = 8,
    parameter int              AW      = 7,
    parameter int              NREG    = 8,
    parameter logic [NREG-1:0] RO_MASK = '0
) (
    input  logic               SCLK,
    input  logic               rst_n,
    input  logic               we_i,
    input  logic [AW-1:0]      waddr_i,
    input  logic [DW-1:0]      wdata_i,
    input  logic [AW-1:0]      raddr_i,
    input  logic [NREG*DW-1:0] ro_data_i,
    output logic [DW-1:0]      rdata_o,
    output logic               wr_ok_o,
    output logic [NREG*DW-1:0] regs_o
);

    logic [NREG*DW-1:0] mem_q;

    // Addresses outside 0..NREG-1 match no entry, so they read 0 and refuse writes.
    always_comb begin
        rdata_o = '0;
        wr_ok_o = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            if (raddr_i == AW'(i))
                rdata_o = RO_MASK[i] ? ro_data_i[i*DW +: DW] : mem_q[i*DW +: DW];
            if (waddr_i == AW'(i))
                wr_ok_o = !RO_MASK[i];
        end
    end

    always_ff @(posedge SCLK or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '0;
        end else if (we_i && wr_ok_o) begin
            for (int i = 0; i < NREG; i++)
                if (waddr_i == AW'(i))
                    mem_q[i*DW +: DW] <= wdata_i;
        end
    end

    assign regs_o = mem_q;

endmodule

// File: rtl/spi_regfile_slave.sv
// SPI mode-0 slave giving a serial master burst read/write access to a register bank.
module spi_regfile_slave
    import spi_regfile_pkg::*;
#(
    parameter int              DW      = 8,
    parameter int              AW      = 7,
    parameter int              NREG    = 8,
    parameter logic [NREG-1:0] RO_MASK = '0
) (
    input  logic               SCLK,
    input  logic               rst_n,
    input  logic               SV_n,
    input  logic               SI,
    output logic               SO,
    output logic               so_oe,
    output logic [NREG*DW-1:0] regs,
    input  logic [NREG*DW-1:0] ro_data,
    output logic               wr_stb,
    output logic [AW-1:0]      wr_addr,
    output logic [1:0]         state_o
);

    localparam int            HDR_LEN       = hdr_bits(AW);
    localparam int            CW            = cnt_width(AW, DW);
    localparam logic [CW-1:0] CNT_HDR_LAST  = CW'(HDR_LEN - 1);
    localparam logic [CW-1:0] CNT_WORD_LAST = CW'(DW - 1);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-2:0]   rx_q, rx_d;
    logic [DW-1:0]   tx_q, tx_d;
    logic            wr_stb_q, wr_stb_d;
    logic [AW-1:0]   wr_addr_q, wr_addr_d;
    logic            abort_q;
    logic            so_q, so_oe_q;
    logic            wr_req, wr_ok;
    logic [AW-1:0]   hdr_addr, rd_addr;
    logic [DW-1:0]   wr_word, rd_word;
    logic            frame_rst_n;

    // Frame state is cleared by reset or by chip-select going inactive.
    assign frame_rst_n = rst_n & ~SV_n;
    // During the header addr_q doubles as the header shifter; its MSB holds R/W.
    assign hdr_addr    = {addr_q[AW-2:0], SI};
    assign rd_addr     = (state_q == ST_HDR) ? hdr_addr : addr_q + AW'(1);
    assign wr_word     = {rx_q, SI};

    spi_regbank #(
        .DW      (DW),
        .AW      (AW),
        .NREG    (NREG),
        .RO_MASK (RO_MASK)
    ) u_regbank (
        .SCLK      (SCLK),
        .rst_n     (rst_n),
        .we_i      (wr_req),
        .waddr_i   (addr_q),
        .wdata_i   (wr_word),
        .raddr_i   (rd_addr),
        .ro_data_i (ro_data),
        .rdata_o   (rd_word),
        .wr_ok_o   (wr_ok),
        .regs_o    (regs)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        rx_d      = rx_q;
        tx_d      = tx_q;
        wr_req    = 1'b0;
        wr_stb_d  = 1'b0;
        wr_addr_d = wr_addr_q;
        if (!abort_q) begin
            cnt_d = cnt_q + CW'(1);
            rx_d  = wr_word[DW-2:0];
            tx_d  = {tx_q[DW-2:0], 1'b0};
            unique case (state_q)
                ST_HDR: begin
                    addr_d = hdr_addr;
                    if (cnt_q == CNT_HDR_LAST) begin
                        cnt_d   = '0;
                        tx_d    = rd_word;
                        state_d = addr_q[AW-1] ? ST_RD : ST_WR;
                    end
                end
                ST_WR: begin
                    if (cnt_q == CNT_WORD_LAST) begin
                        cnt_d    = '0;
                        wr_req   = 1'b1;
                        wr_stb_d = wr_ok;
                        if (wr_ok)
                            wr_addr_d = addr_q;
                        addr_d = addr_q + AW'(1);
                    end
                end
                ST_RD: begin
                    if (cnt_q == CNT_WORD_LAST) begin
                        cnt_d  = '0;
                        tx_d   = rd_word;
                        addr_d = addr_q + AW'(1);
                    end
                end
                default: state_d = ST_HDR;
            endcase
        end
    end

    always_ff @(posedge SCLK or negedge frame_rst_n) begin
        if (!frame_rst_n) begin
            state_q  <= ST_HDR;
            cnt_q    <= '0;
            addr_q   <= '0;
            rx_q     <= '0;
            tx_q     <= '0;
            wr_stb_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            rx_q     <= rx_d;
            tx_q     <= tx_d;
            wr_stb_q <= wr_stb_d;
        end
    end

    always_ff @(posedge SCLK or negedge rst_n) begin
        if (!rst_n)
            wr_addr_q <= '0;
        else
            wr_addr_q <= wr_addr_d;
    end

    // A reset inside a frame locks out the rest of that frame until chip-select deasserts.
    always_ff @(posedge SCLK or posedge SV_n or negedge rst_n) begin
        if (SV_n)
            abort_q <= 1'b0;
        else if (!rst_n)
            abort_q <= 1'b1;
        else
            abort_q <= abort_q;
    end

    always_ff @(negedge SCLK or negedge frame_rst_n) begin
        if (!frame_rst_n)
            so_oe_q <= 1'b0;
        else
            so_oe_q <= (state_q == ST_RD);
    end

    always_ff @(negedge SCLK or negedge rst_n) begin
        if (!rst_n)
            so_q <= 1'b0;
        else if (state_q == ST_RD)
            so_q <= tx_q[DW-1];
    end

    assign SO      = so_q;
    assign so_oe   = so_oe_q;
    assign wr_stb  = wr_stb_q;
    assign wr_addr = wr_addr_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_spi_regfile_slave.sv
// Bench for spi_regfile_slave: directed frames, random bursts, aborts and resets against a register model.
module tb_spi_regfile_slave;

    localparam int              DW      = 8;
    localparam int              AW      = 7;
    localparam int              NREG    = 8;
    localparam logic [NREG-1:0] RO_MASK = 8'h80;
    localparam int              ASPACE  = 1 << AW;

    logic               SCLK, rst_n, SV_n, SI;
    logic               SO, so_oe, wr_stb;
    logic [NREG*DW-1:0] regs, ro_data;
    logic [AW-1:0]      wr_addr;
    logic [1:0]         state_o;

    int n_vec = 0;
    int n_err = 0;

    logic [DW-1:0] model_mem [NREG];
    logic [AW-1:0] model_wr_addr;
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] tx_words [$];

    spi_regfile_slave #(
        .DW(DW), .AW(AW), .NREG(NREG), .RO_MASK(RO_MASK)
    ) dut (
        .SCLK    (SCLK),
        .rst_n   (rst_n),
        .SV_n    (SV_n),
        .SI      (SI),
        .SO      (SO),
        .so_oe   (so_oe),
        .regs    (regs),
        .ro_data (ro_data),
        .wr_stb  (wr_stb),
        .wr_addr (wr_addr),
        .state_o (state_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [DW-1:0] model_word(input int a);
        if (a >= NREG) return '0;
        if (RO_MASK[a]) return ro_data[a*DW +: DW];
        return model_mem[a];
    endfunction

    function automatic bit model_writable(input int a);
        if (a >= NREG) return 1'b0;
        return !RO_MASK[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) model_mem[i] = '0;
        model_wr_addr = '0;
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < NREG; i++)
            check($sformatf("%s_w%0d", tag, i), regs[i*DW +: DW], model_mem[i]);
    endtask

    // ---------------- SPI master driver ----------------
    task automatic spi_bit(input logic b, output logic so_s, output logic oe_s, output logic stb_s);
        SI = b;
        #3;
        so_s = SO;
        oe_s = so_oe;
        #2;
        SCLK = 1'b1;
        #2;
        stb_s = wr_stb;
        #3;
        SCLK = 1'b0;
    endtask

    task automatic frame_begin();
        SV_n = 1'b0;
        #5;
    endtask

    task automatic frame_end();
        #5;
        SV_n = 1'b1;
        #5;
        check("stb_idle", wr_stb, 1'b0);
        check("oe_idle", so_oe, 1'b0);
        #5;
    endtask

    task automatic send_header(input logic rw, input int a);
        logic [AW-1:0] av;
        logic [AW:0]   h;
        logic          so_s, oe_s, stb_s;
        bit            oe_seen;
        av = a[AW-1:0];
        h  = {rw, av};
        oe_seen = 1'b0;
        for (int i = AW; i >= 0; i--) begin
            spi_bit(h[i], so_s, oe_s, stb_s);
            if (oe_s) oe_seen = 1'b1;
        end
        check("hdr_oe", oe_seen, 1'b0);
    endtask

    task automatic write_frame(input int a);
        logic [DW-1:0] d;
        logic          so_s, oe_s, stb_s;
        bit            stb_early, exp_stb;
        int            cur;
        frame_begin();
        send_header(1'b0, a);
        cur = a;
        while (tx_words.size() > 0) begin
            d = tx_words.pop_front();
            stb_early = 1'b0;
            for (int i = DW - 1; i >= 0; i--) begin
                spi_bit(d[i], so_s, oe_s, stb_s);
                if (i > 0 && stb_s) stb_early = 1'b1;
            end
            exp_stb = model_writable(cur);
            if (exp_stb) begin
                model_mem[cur] = d;
                model_wr_addr  = cur[AW-1:0];
            end
            check("wr_stb", stb_s, exp_stb);
            check("wr_stb_width", stb_early, 1'b0);
            check("wr_addr", wr_addr, model_wr_addr);
            check_regs("wr_regs");
            cur = (cur + 1) % ASPACE;
        end
        frame_end();
    endtask

    task automatic read_frame(input int a, input int n);
        logic [DW-1:0] got;
        logic          so_s, oe_s, stb_s;
        bit            oe_all;
        int            cur;
        frame_begin();
        send_header(1'b1, a);
        cur = a;
        for (int w = 0; w < n; w++) begin
            exp_q.push_back(model_word(cur));
            got    = '0;
            oe_all = 1'b1;
            for (int i = 0; i < DW; i++) begin
                spi_bit(1'b0, so_s, oe_s, stb_s);
                got = {got[DW-2:0], so_s};
                if (!oe_s) oe_all = 1'b0;
            end
            check($sformatf("rd_data_a%0d", cur), got, exp_q.pop_front());
            check("rd_oe", oe_all, 1'b1);
            cur = (cur + 1) % ASPACE;
        end
        frame_end();
    endtask

    task automatic partial_write(input int a, input int nbits);
        logic so_s, oe_s, stb_s;
        bit   stb_seen;
        stb_seen = 1'b0;
        frame_begin();
        send_header(1'b0, a);
        for (int i = 0; i < nbits; i++) begin
            spi_bit(1'($urandom_range(0, 1)), so_s, oe_s, stb_s);
            if (stb_s) stb_seen = 1'b1;
        end
        frame_end();
        check("partial_stb", stb_seen, 1'b0);
        check_regs("partial_regs");
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic so_s, oe_s, stb_s;
        bit   stb_seen;
        int   a, n;

        SCLK    = 1'b0;
        SV_n    = 1'b1;
        SI      = 1'b0;
        rst_n   = 1'b1;
        ro_data = '0;
        ro_data[7*DW +: DW] = 8'h7E;
        model_reset();
        #1;
        rst_n = 1'b0;
        #20;
        check("rst_so", SO, 1'b0);
        check("rst_oe", so_oe, 1'b0);
        check("rst_stb", wr_stb, 1'b0);
        check("rst_wr_addr", wr_addr, '0);
        check("rst_state", state_o, 2'd0);
        check_regs("rst_regs");
        rst_n = 1'b1;
        #10;

        // Single write of 0xA5 to address 3.
        tx_words.push_back(8'hA5);
        write_frame(3);

        // Burst from 6 runs past the last implemented register.
        tx_words.push_back(8'h11);
        tx_words.push_back(8'h22);
        tx_words.push_back(8'h33);
        write_frame(6);

        // Read burst over freshly written registers 2 and 3.
        tx_words.push_back(8'h5A);
        write_frame(2);
        tx_words.push_back(8'hC3);
        write_frame(3);
        read_frame(2, 2);

        // Read-only status word and out-of-range read.
        tx_words.push_back(8'hFF);
        write_frame(7);
        read_frame(7, 1);
        read_frame(8'h40, 1);

        // Partial word is discarded, next frame behaves normally.
        partial_write(1, 5);
        tx_words.push_back(8'h96);
        write_frame(1);
        read_frame(1, 1);

        // Bursts that wrap through the top of the address space.
        tx_words.push_back(8'hE7);
        tx_words.push_back(8'h3C);
        write_frame(ASPACE - 1);
        read_frame(ASPACE - 1, 2);

        // Randomised frames with status word changing between frames.
        for (int f = 0; f < 40; f++) begin
            ro_data[7*DW +: DW] = DW'($urandom_range(0, 255));
            case ($urandom_range(0, 5))
                0:       a = $urandom_range(0, ASPACE - 1);
                1:       a = ASPACE - 1;
                default: a = $urandom_range(0, NREG + 1);
            endcase
            n = $urandom_range(1, 3);
            if ($urandom_range(0, 1) == 1) begin
                for (int k = 0; k < n; k++) tx_words.push_back(DW'($urandom_range(0, 255)));
                write_frame(a);
            end else begin
                read_frame(a, n);
            end
            if ($urandom_range(0, 7) == 0) partial_write($urandom_range(0, NREG - 1), $urandom_range(1, DW - 1));
        end

        // Reset in the middle of a read burst.
        tx_words.push_back(8'h5A);
        write_frame(2);
        frame_begin();
        send_header(1'b1, 2);
        for (int i = 0; i < 3; i++) spi_bit(1'b0, so_s, oe_s, stb_s);
        rst_n = 1'b0;
        #2;
        model_reset();
        check("midrst_so", SO, 1'b0);
        check("midrst_oe", so_oe, 1'b0);
        check("midrst_wr_addr", wr_addr, '0);
        check_regs("midrst_regs");
        #5;
        rst_n = 1'b1;
        #5;
        check("midrst_state", state_o, 2'd0);
        // Remaining clocks of the aborted frame look like a write of 0xFF to 0 and must be ignored.
        send_header(1'b0, 0);
        stb_seen = 1'b0;
        for (int i = 0; i < DW; i++) begin
            spi_bit(1'b1, so_s, oe_s, stb_s);
            if (stb_s) stb_seen = 1'b1;
        end
        check("abort_stb", stb_seen, 1'b0);
        frame_end();
        check_regs("abort_regs");
        read_frame(0, 1);
        tx_words.push_back(8'h42);
        write_frame(0);
        read_frame(0, 1);

        if (exp_q.size() != 0) check("exp_q_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/spi_regfile_slave.md
# spi_regfile_slave

Parametrised SPI-slave register file: a serial master reads and writes a bank of NREG control/status words of DW bits through a 4-wire SPI port (mode 0), with multi-word burst transfers and address auto-increment. It is the next-generation configuration port between the chip pads and the core. Write registers drive the core directly; read-only status words are sampled from the core. All logic runs on SCLK only, and the frame logic is cleared by chip-select.

## Interface
Parameters:
- DW, 8: data word width (≥2).
- AW, 7: address width.
- NREG, 8: implemented registers, addresses 0..NREG-1 (NREG ≤ 2^AW).
- RO_MASK, 0 (NREG bits): bit i set means register i is read-only and returns ro_data word i.

Ports:
- SCLK, in, 1: SPI clock, the only clock.
- rst_n, in, 1: reset, asynchronous, active-low.
- SV_n, in, 1: chip select, active-low; high asynchronously clears frame state.
- SI, in, 1: serial data in, MSB first.
- SO, out, 1: serial data out, MSB first.
- so_oe, out, 1: high while SO carries read data, for the pad tri-state.
- regs, out, NREG*DW: flat register bank, word i at [i*DW +: DW].
- ro_data, in, NREG*DW: status words for RO_MASK registers; quasi-static, sampled at load.
- wr_stb, out, 1: pulse, one SCLK period, after each committed write.
- wr_addr, out, AW: address of the last committed write.

## Operation
- Frame: header of 1+AW bits {R/W (1 = read), ADDR[AW-1:0]}, then any number of DW-bit data words. SI is sampled on SCLK rise; SO changes on SCLK fall.
- FSM states: HDR, WR, RD.
  - HDR→WR or HDR→RD on the rising edge of the last header bit; the address is latched on the same edge.
  - WR and RD hold until SV_n rises.
  - SV_n high forces HDR asynchronously and clears the bit counter, rx/tx shifters, so_oe and wr_stb.
- Write: rx shifts DW bits. On the rising edge of the last bit, if addr < NREG and RO_MASK[addr] = 0, then regs[addr] ← {rx[DW-2:0], SI}, wr_stb = 1, wr_addr = addr. Otherwise the write is dropped silently and wr_stb stays 0. Then addr increments.
- Read: tx is loaded with word[addr] on the rising edge of the last header bit. tx shifts left on each data rising edge. On the rising edge of the last data bit, addr increments and tx reloads with the next word.
  - word = ro_data word if RO_MASK set, else regs word; 0 if addr ≥ NREG.
  - SO register ← tx[DW-1] on every falling edge while in RD.
- Address increments modulo 2^AW (wraps to 0); out-of-range addresses read 0.
- A partial word at SV_n rise is discarded; registers are unchanged.
- rst_n low at any time:
  - regs = 0, SO = 0, so_oe = 0, wr_stb = 0, wr_addr = 0, FSM = HDR.
  - A mid-frame reset aborts the frame. Transfer resumes only on a new frame after SV_n goes high then low.

## Timing
- Header = 1+AW SCLK cycles (8 at default), with no dead cycle before data.
- Write latency: regs updates on the same rising edge that samples the last data bit. wr_stb is high from that edge to the next rising edge, or until SV_n rises.
- Read: the first data MSB is valid on SO after the falling edge that follows the last header bit, so the master samples it on the next rising edge. so_oe goes high on that same falling edge.
- Burst word n+1 follows word n with no gap.
- A write and a read of the same register in different frames return the new value. A read burst covering a register the core changes mid-word returns the value sampled at load.

## Structure
- Package spi_regfile_pkg holds:
  - the state enum {HDR, WR, RD};
  - the localparam HDR_BITS = 1+AW helper;
  - the bit-counter width function clog2(max(HDR_BITS, DW)).
- One sub-module, spi_regbank: NREG×DW storage with write port (addr, data, we), the RO_MASK/ro_data read mux, and the out-of-range zero. The top level holds the shifters, counter and FSM.

## Test plan
- Write 0x03, 0xA5 (header 0_0000011, data 10100101) → regs word3 = 0xA5 after the 16th rising edge; wr_stb for one cycle; wr_addr = 3.
- Burst write at addr 6 with data 0x11, 0x22, 0x33 → word6 = 0x11, word7 = 0x22, addr 8 dropped, and with the default AW = 7 addr does not wrap to 0, so word0 is unchanged; two wr_stb pulses.
- Read burst at addr 2, after prior writes 0x5A to 2 and 0xC3 to 3 → SO bits give 0x5A then 0xC3; so_oe high only during data.
- RO_MASK = 8'h80, ro_data word7 = 0x7E: a write of 0xFF to 7 is ignored (no wr_stb), and a read of 7 returns 0x7E. A read of addr 0x40 returns 0x00.
- SV_n rises after 5 data bits of a write to 1 → word1 unchanged. The next full frame works normally.
- rst_n pulsed low mid read burst → SO = 0, so_oe = 0, regs = 0. A fresh read of 0 returns 0x00.
